// File: rtl/jelly2_video_sync_to_axi4s_pkg.sv
// Shared types and helpers for the video sync to AXI4-Stream framer.
// The saturating increment serves both the column and row counters.
package jelly2_video_sync_to_axi4s_pkg;

   typedef enum logic [1:0] {
      WAIT_VSYNC = 2'd0,
      ARMED      = 2'd1,
      ACTIVE     = 2'd2
   } state_t;

   // Counters narrower than this are zero-extended into the helper.
   localparam int unsigned SAT_W = 16;

   function automatic logic [SAT_W-1:0] satInc(input logic [SAT_W-1:0] value,
                                               input logic [SAT_W-1:0] maxValue);
      return (value == maxValue) ? value : value + SAT_W'(1);
   endfunction

endpackage

// File: rtl/jelly2_video_sync_measure.sv
// Raster geometry measurement: active width/height and a sticky error
// raised when a line's width differs from the first line of its frame.
module jelly2_video_sync_measure
   import jelly2_video_sync_to_axi4s_pkg::*;
#(
   parameter int unsigned X_WIDTH = 12,
   parameter int unsigned Y_WIDTH = 11
)
(
   input  logic               clk_i,
   input  logic               resetn_i,
   input  logic               enable_i,
   input  logic               pixel_i,
   input  logic               lineEnd_i,
   input  logic               frameStart_i,
   output logic [X_WIDTH-1:0] width_o,
   output logic [Y_WIDTH-1:0] height_o,
   output logic               err_o
);

   localparam logic [SAT_W-1:0] X_MAX = SAT_W'({X_WIDTH{1'b1}});
   localparam logic [SAT_W-1:0] Y_MAX = SAT_W'({Y_WIDTH{1'b1}});

   logic [X_WIDTH-1:0] colCnt_q, colCnt_d;
   logic [X_WIDTH-1:0] refWidth_q, refWidth_d;
   logic [X_WIDTH-1:0] width_q, width_d;
   logic [Y_WIDTH-1:0] rowCnt_q, rowCnt_d;
   logic [Y_WIDTH-1:0] height_q, height_d;
   logic               refValid_q, refValid_d;
   logic               err_q, err_d;
   logic [X_WIDTH-1:0] colInc;
   logic [Y_WIDTH-1:0] rowInc;

   assign colInc = X_WIDTH'(satInc(SAT_W'(colCnt_q), X_MAX));
   assign rowInc = Y_WIDTH'(satInc(SAT_W'(rowCnt_q), Y_MAX));

   // A line closed by a vsync edge still belongs to the frame that is ending.
   always_comb begin
      colCnt_d   = colCnt_q;
      refWidth_d = refWidth_q;
      refValid_d = refValid_q;
      width_d    = width_q;
      rowCnt_d   = rowCnt_q;
      height_d   = height_q;
      err_d      = err_q;

      if (lineEnd_i) begin
         colCnt_d = pixel_i ? X_WIDTH'(1) : '0;
         width_d  = colCnt_q;
         if (refValid_q && (colCnt_q != refWidth_q)) begin
            err_d = 1'b1;
         end
      end else if (pixel_i) begin
         colCnt_d = colInc;
      end

      if (frameStart_i) begin
         height_d   = lineEnd_i ? rowInc : rowCnt_q;
         rowCnt_d   = '0;
         refValid_d = 1'b0;
      end else if (lineEnd_i) begin
         rowCnt_d = rowInc;
         if (!refValid_q) begin
            refValid_d = 1'b1;
            refWidth_d = colCnt_q;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!resetn_i) begin
         colCnt_q   <= '0;
         refWidth_q <= '0;
         refValid_q <= 1'b0;
         width_q    <= '0;
         rowCnt_q   <= '0;
         height_q   <= '0;
         err_q      <= 1'b0;
      end else if (enable_i) begin
         colCnt_q   <= colCnt_d;
         refWidth_q <= refWidth_d;
         refValid_q <= refValid_d;
         width_q    <= width_d;
         rowCnt_q   <= rowCnt_d;
         height_q   <= height_d;
         err_q      <= err_d;
      end
   end

   assign width_o  = width_q;
   assign height_o = height_q;
   assign err_o    = err_q;

endmodule

// File: rtl/jelly2_video_sync_to_axi4s.sv
// Raster timing (vsync/de/data) to AXI4-Stream video framing with tuser/tlast.
// Define JELLY2_VIDEO_SYNC_TO_AXI4S_MEASURE_EN to build width/height/error measurement.
module jelly2_video_sync_to_axi4s
   import jelly2_video_sync_to_axi4s_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 24,
   parameter int unsigned X_WIDTH    = 12,
   parameter int unsigned Y_WIDTH    = 11,
   parameter logic        VSYNC_POL  = 1'b1,
   parameter logic        HSYNC_POL  = 1'b1
)
(
   input  logic                  aclk,
   input  logic                  aresetn,
   input  logic                  aclken,
   input  logic                  in_vsync,
   input  logic                  in_hsync,
   input  logic                  in_de,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  m_axi4s_tuser,
   output logic                  m_axi4s_tlast,
   output logic [DATA_WIDTH-1:0] m_axi4s_tdata,
   output logic                  m_axi4s_tvalid,
   output logic [X_WIDTH-1:0]    out_width,
   output logic [Y_WIDTH-1:0]    out_height,
   output logic                  out_err
);

   state_t                state_q;
   logic                  vsyncPrev_q;
   logic                  holdValid_q;
   logic                  holdUser_q;
   logic [DATA_WIDTH-1:0] holdData_q;

   logic   vsyncActive;
   logic   vsyncRise;
   logic   lineClose;
   logic   accept;
   state_t effState;

   logic unusedSignals;
   assign unusedSignals = ^{in_hsync, HSYNC_POL};

   assign vsyncActive = (in_vsync == VSYNC_POL);
   assign vsyncRise   = vsyncActive && !vsyncPrev_q;
   assign effState    = vsyncRise ? ARMED : state_q;
   assign accept      = in_de && (effState != WAIT_VSYNC);
   // The held pixel ends its line when de drops or a new frame begins under it.
   assign lineClose   = holdValid_q && (!in_de || vsyncRise);

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state_q     <= WAIT_VSYNC;
         vsyncPrev_q <= 1'b0;
         holdValid_q <= 1'b0;
         holdUser_q  <= 1'b0;
         holdData_q  <= '0;
      end else if (aclken) begin
         vsyncPrev_q <= vsyncActive;
         holdValid_q <= accept;
         holdUser_q  <= accept && (effState == ARMED);
         if (accept) begin
            holdData_q <= in_data;
         end
         state_q <= (accept && (effState == ARMED)) ? ACTIVE : effState;
      end
   end

   assign m_axi4s_tvalid = holdValid_q;
   assign m_axi4s_tuser  = holdUser_q;
   assign m_axi4s_tlast  = lineClose;
   assign m_axi4s_tdata  = holdData_q;

`ifdef JELLY2_VIDEO_SYNC_TO_AXI4S_MEASURE_EN
   jelly2_video_sync_measure #(
      .X_WIDTH (X_WIDTH),
      .Y_WIDTH (Y_WIDTH)
   ) uMeasure (
      .clk_i        (aclk),
      .resetn_i     (aresetn),
      .enable_i     (aclken),
      .pixel_i      (accept),
      .lineEnd_i    (lineClose),
      .frameStart_i (vsyncRise),
      .width_o      (out_width),
      .height_o     (out_height),
      .err_o        (out_err)
   );
`else
   assign out_width  = '0;
   assign out_height = '0;
   assign out_err    = 1'b0;
`endif

endmodule

// File: tb/tb_jelly2_video_sync_to_axi4s.sv
// Directed bench for jelly2_video_sync_to_axi4s: 8x4 rasters, reset, short line,
// mid-line vsync and clock-enable toggling, with hand-derived beat expectations.
module tb_jelly2_video_sync_to_axi4s;

`ifdef JELLY2_VIDEO_SYNC_TO_AXI4S_MEASURE_EN
   localparam bit MEAS = 1'b1;
`else
   localparam bit MEAS = 1'b0;
`endif

   localparam int W  = 8;
   localparam int H  = 4;
   localparam int HB = 4;

   logic        aclk = 1'b0;
   logic        aresetn = 1'b0;
   logic        aclken = 1'b1;
   logic        inVsync = 1'b0;
   logic        inHsync = 1'b0;
   logic        inDe = 1'b0;
   logic [23:0] inData = '0;
   logic        mTuser, mTlast, mTvalid;
   logic [23:0] mTdata;
   logic [11:0] outWidth;
   logic [10:0] outHeight;
   logic        outErr;

   int errors = 0;
   int checks = 0;
   bit toggleEn = 1'b0;
   logic [25:0] beats[$];

   always #5 aclk = ~aclk;

   jelly2_video_sync_to_axi4s dut (
      .aclk           (aclk),
      .aresetn        (aresetn),
      .aclken         (aclken),
      .in_vsync       (inVsync),
      .in_hsync       (inHsync),
      .in_de          (inDe),
      .in_data        (inData),
      .m_axi4s_tuser  (mTuser),
      .m_axi4s_tlast  (mTlast),
      .m_axi4s_tdata  (mTdata),
      .m_axi4s_tvalid (mTvalid),
      .out_width      (outWidth),
      .out_height     (outHeight),
      .out_err        (outErr)
   );

   function automatic logic [23:0] pix(input int f, input int y, input int x);
      return {f[7:0], y[7:0], x[7:0]};
   endfunction

   // One enabled cycle; beats are captured mid-cycle, away from the clock edge.
   task automatic step(input logic vs, input logic de, input logic [23:0] d);
      inVsync = vs;
      inDe    = de;
      inHsync = !de;
      inData  = d;
      aclken  = 1'b1;
      @(negedge aclk);
      if (mTvalid === 1'b1) beats.push_back({mTuser, mTlast, mTdata});
      @(posedge aclk);
      #1;
      if (toggleEn) begin
         aclken = 1'b0;
         @(posedge aclk);
         #1;
         aclken = 1'b1;
      end
   endtask

   task automatic sendFrame(input int f, input int shortLine, input int shortLen);
      for (int l = 0; l < 2; l++)
         for (int c = 0; c < W + HB; c++) step(l == 0, 1'b0, '0);
      for (int y = 0; y < H; y++) begin
         int len;
         len = (y == shortLine) ? shortLen : W;
         for (int x = 0; x < len; x++) step(1'b0, 1'b1, pix(f, y, x));
         for (int c = 0; c < HB; c++) step(1'b0, 1'b0, '0);
      end
   endtask

   task automatic sendTail();
      for (int c = 0; c < W + HB; c++) step(1'b1, 1'b0, '0);
      for (int c = 0; c < HB; c++) step(1'b0, 1'b0, '0);
   endtask

   task automatic test_reset();
      aresetn = 1'b0;
      inVsync = 1'b1;
      inDe    = 1'b1;
      inData  = 24'hABCDEF;
      repeat (3) @(posedge aclk);
      @(negedge aclk);
      checks++; if (mTvalid !== 1'b0) begin errors++; $display("[TB] FAIL reset tvalid: got %b expected 0", mTvalid); end
      checks++; if (mTuser !== 1'b0) begin errors++; $display("[TB] FAIL reset tuser: got %b expected 0", mTuser); end
      checks++; if (mTlast !== 1'b0) begin errors++; $display("[TB] FAIL reset tlast: got %b expected 0", mTlast); end
      checks++; if (mTdata !== 24'h0) begin errors++; $display("[TB] FAIL reset tdata: got %h expected 0", mTdata); end
      checks++; if (outWidth !== 12'd0) begin errors++; $display("[TB] FAIL reset width: got %0d expected 0", outWidth); end
      checks++; if (outHeight !== 11'd0) begin errors++; $display("[TB] FAIL reset height: got %0d expected 0", outHeight); end
      checks++; if (outErr !== 1'b0) begin errors++; $display("[TB] FAIL reset err: got %b expected 0", outErr); end
      inVsync = 1'b0;
      inDe    = 1'b0;
      inData  = '0;
      @(posedge aclk);
      #1;
      aresetn = 1'b1;
   endtask

   task automatic test_raster(input string name);
      logic [25:0] got, exp;
      beats.delete();
      sendFrame(0, -1, W);
      sendFrame(1, -1, W);
      sendTail();
      checks++;
      if (beats.size() != 64) begin errors++; $display("[TB] FAIL %s count: got %0d expected 64", name, beats.size()); end
      for (int f = 0; f < 2; f++)
         for (int b = 0; b < 32; b++) begin
            exp = {b == 0, (b % 8) == 7, pix(f, b / 8, b % 8)};
            got = (f * 32 + b < beats.size()) ? beats[f * 32 + b] : 'x;
            checks++;
            if (got !== exp) begin errors++; $display("[TB] FAIL %s beat %0d: got %h expected %h", name, f * 32 + b, got, exp); end
         end
      checks++; if (outWidth !== (MEAS ? 12'd8 : 12'd0)) begin errors++; $display("[TB] FAIL %s width: got %0d expected %0d", name, outWidth, MEAS ? 8 : 0); end
      checks++; if (outHeight !== (MEAS ? 11'd4 : 11'd0)) begin errors++; $display("[TB] FAIL %s height: got %0d expected %0d", name, outHeight, MEAS ? 4 : 0); end
      checks++; if (outErr !== 1'b0) begin errors++; $display("[TB] FAIL %s err: got %b expected 0", name, outErr); end
   endtask

   task automatic test_aclken_toggle();
      toggleEn = 1'b1;
      test_raster("toggle");
      toggleEn = 1'b0;
   endtask

   task automatic test_pre_vsync();
      logic [25:0] got, exp;
      for (int x = 0; x < 3; x++) step(1'b0, 1'b1, pix(9, 0, x));
      aresetn = 1'b0;
      step(1'b0, 1'b1, pix(9, 0, 3));
      step(1'b0, 1'b1, pix(9, 0, 4));
      aresetn = 1'b1;
      beats.delete();
      for (int x = 0; x < 10; x++) step(1'b0, 1'b1, pix(9, 1, x));
      for (int c = 0; c < HB; c++) step(1'b0, 1'b0, '0);
      checks++;
      if (beats.size() != 0) begin errors++; $display("[TB] FAIL prevsync count: got %0d expected 0", beats.size()); end
      sendFrame(5, -1, W);
      sendTail();
      checks++;
      if (beats.size() != 32) begin errors++; $display("[TB] FAIL prevsync frame count: got %0d expected 32", beats.size()); end
      exp = {1'b1, 1'b0, pix(5, 0, 0)};
      got = (beats.size() > 0) ? beats[0] : 'x;
      checks++; if (got !== exp) begin errors++; $display("[TB] FAIL prevsync first beat: got %h expected %h", got, exp); end
      exp = {1'b0, 1'b1, pix(5, 3, 7)};
      got = (beats.size() > 31) ? beats[31] : 'x;
      checks++; if (got !== exp) begin errors++; $display("[TB] FAIL prevsync last beat: got %h expected %h", got, exp); end
      checks++; if (outHeight !== (MEAS ? 11'd4 : 11'd0)) begin errors++; $display("[TB] FAIL prevsync height: got %0d expected %0d", outHeight, MEAS ? 4 : 0); end
      checks++; if (outErr !== 1'b0) begin errors++; $display("[TB] FAIL prevsync err: got %b expected 0", outErr); end
   endtask

   task automatic test_short_line();
      logic [25:0] got, exp;
      int idx, len;
      beats.delete();
      sendFrame(2, 1, 6);
      sendTail();
      checks++;
      if (beats.size() != 30) begin errors++; $display("[TB] FAIL short count: got %0d expected 30", beats.size()); end
      idx = 0;
      for (int y = 0; y < H; y++) begin
         len = (y == 1) ? 6 : W;
         for (int x = 0; x < len; x++) begin
            exp = {idx == 0, x == len - 1, pix(2, y, x)};
            got = (idx < beats.size()) ? beats[idx] : 'x;
            checks++;
            if (got !== exp) begin errors++; $display("[TB] FAIL short beat %0d: got %h expected %h", idx, got, exp); end
            idx++;
         end
      end
      checks++; if (outErr !== MEAS) begin errors++; $display("[TB] FAIL short err: got %b expected %b", outErr, MEAS); end
      beats.delete();
      sendFrame(3, -1, W);
      sendTail();
      checks++; if (outErr !== MEAS) begin errors++; $display("[TB] FAIL short sticky err: got %b expected %b", outErr, MEAS); end
      checks++; if (outWidth !== (MEAS ? 12'd8 : 12'd0)) begin errors++; $display("[TB] FAIL short width: got %0d expected %0d", outWidth, MEAS ? 8 : 0); end
      exp = {1'b1, 1'b0, pix(3, 0, 0)};
      got = (beats.size() > 0) ? beats[0] : 'x;
      checks++; if (got !== exp) begin errors++; $display("[TB] FAIL short next frame beat: got %h expected %h", got, exp); end
   endtask

   task automatic test_midline_vsync();
      logic [25:0] got, exp;
      logic [25:0] expTab[$];
      sendFrame(4, -1, W);
      beats.delete();
      for (int x = 0; x < 3; x++) step(1'b0, 1'b1, pix(6, 0, x));
      for (int x = 0; x < W; x++) step(1'b1, 1'b1, pix(7, 0, x));
      for (int c = 0; c < HB; c++) step(1'b1, 1'b0, '0);
      for (int c = 0; c < HB; c++) step(1'b0, 1'b0, '0);
      expTab.push_back({1'b0, 1'b0, pix(6, 0, 0)});
      expTab.push_back({1'b0, 1'b0, pix(6, 0, 1)});
      expTab.push_back({1'b0, 1'b1, pix(6, 0, 2)});
      for (int x = 0; x < W; x++) expTab.push_back({x == 0, x == W - 1, pix(7, 0, x)});
      checks++;
      if (beats.size() != 11) begin errors++; $display("[TB] FAIL midline count: got %0d expected 11", beats.size()); end
      for (int i = 0; i < 11; i++) begin
         exp = expTab[i];
         got = (i < beats.size()) ? beats[i] : 'x;
         checks++;
         if (got !== exp) begin errors++; $display("[TB] FAIL midline beat %0d: got %h expected %h", i, got, exp); end
      end
   endtask

   initial begin
      test_reset();
      test_raster("raster");
      test_aclken_toggle();
      test_pre_vsync();
      test_short_line();
      test_midline_vsync();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/jelly2_video_sync_to_axi4s.md
# jelly2_video_sync_to_axi4s

Converts a raster video timing stream (vsync/hsync/de plus pixel data) into AXI4-Stream video framing: tuser on the first pixel of a frame, tlast on the last pixel of each line. It sits between the pattern/draw stage and the DVI/HDMI output path, and provides the framed stream consumed by frame capture (`jelly2_axi4s_slave_model`) in simulation. It also measures the active width and height of the incoming raster.

## Interface
- DATA_WIDTH, 24, pixel data width (RGB 8:8:8)
- X_WIDTH, 12, width of the column counter and measured width
- Y_WIDTH, 11, width of the row counter and measured height
- VSYNC_POL, 1'b1, active level of in_vsync
- HSYNC_POL, 1'b1, active level of in_hsync

Ports:
- aclk  in  1  pixel clock; single clock domain
- aresetn  in  1  synchronous reset, active-low
- aclken  in  1  clock enable; when low, all state holds
- in_vsync  in  1  vertical sync
- in_hsync  in  1  horizontal sync; informational only
- in_de  in  1  data enable
- in_data  in  DATA_WIDTH  pixel data
- m_axi4s_tuser  out  1  frame start
- m_axi4s_tlast  out  1  line end
- m_axi4s_tdata  out  DATA_WIDTH  pixel
- m_axi4s_tvalid  out  1  pixel valid; no tready (video cannot stall)
- out_width  out  X_WIDTH  last measured active pixels per line
- out_height  out  Y_WIDTH  last measured active lines per frame
- out_err  out  1  sticky error: line width changed within a frame

## Operation
- Vsync edge: in_vsync transitions to its active level (VSYNC_POL) on an enabled cycle.
- One-entry hold register. A pixel accepted with in_de=1 at cycle N is emitted at cycle N+1.
  - tlast = 1 if in_de=0 at cycle N+1, or if a vsync edge occurs at N+1.
- States: WAIT_VSYNC, ARMED, ACTIVE.
  - WAIT_VSYNC: the reset state. Pixels are discarded and tvalid stays 0. A vsync edge moves to ARMED.
  - ARMED: the first de pixel is emitted with tuser=1; state moves to ACTIVE.
  - ACTIVE: pixels stream with tuser=0. A vsync edge moves to ARMED.
- Vsync edge while a pixel is held: that pixel is emitted with tlast forced to 1, so the truncated line is closed.
- Single-cycle de on the first line: emitted with tuser=1 and tlast=1.
- de while vsync is active: pixels pass through normally. Only the edge arms a frame.
- Measurement:
  - A column counter counts de pixels in the current line. It saturates at all-ones.
  - On each line end: out_width is loaded with the count, and the row counter increments (saturating).
  - On a vsync edge: out_height is loaded with the row count, the row counter clears, and the reference width clears.
  - The first line end of a frame sets the reference width. Any later line end whose count differs sets out_err.
  - out_err clears only on reset.

## Timing
- Latency: exactly 1 enabled cycle from in_de/in_data to tvalid/tdata.
- tvalid is asserted on each enabled cycle following an accepted pixel. The consumer samples on aclken=1.
- aclken=0: outputs and all state hold. Held outputs are not new beats.
- Reset values: tvalid=0, tuser=0, tlast=0, tdata=0, out_width=0, out_height=0, out_err=0, state=WAIT_VSYNC.
- Reset mid-line: the held pixel is dropped and no tlast is emitted. Output resumes only after the next vsync edge.
- out_width updates 1 cycle after the line's last de. out_height updates in the vsync edge cycle + 1.

## Configuration
- JELLY2_VIDEO_SYNC_TO_AXI4S_MEASURE_EN defined: column/row counters, out_width, out_height and out_err are implemented.
- Not defined: the counters are not built, out_width, out_height and out_err are tied to 0, and framing behaviour is unchanged.

## Structure
- Package jelly2_video_sync_to_axi4s_pkg contains:
  - state_t enum: WAIT_VSYNC, ARMED, ACTIVE
  - a localparam for the saturation helper width
- Sub-module jelly2_video_sync_measure holds the counters, reference width and error flag. It is instantiated only under the macro.

## Test plan
- Raster 8x4 active, 4-cycle h-blank, 2-line v-blank, 2 frames -> tvalid on 32 beats per frame; tuser on beat 0 only; tlast on beats 7, 15, 23, 31; out_width=8; out_height=4; out_err=0.
- Pixels before the first vsync edge after reset -> tvalid stays 0. The first frame after the edge carries tuser.
- Line 2 shortened to 6 pixels -> tlast on its 6th beat, out_err=1 and stays 1 through later frames.
- Vsync edge mid-line after 3 pixels -> 3rd pixel emitted with tlast=1; the next de pixel carries tuser=1.
- aclken toggling 1/0 every cycle on the 8x4 raster -> beat sequence identical to the first scenario, counted on enabled cycles only.
- Macro undefined, 8x4 raster -> same framing as the first scenario; out_width=0, out_height=0, out_err=0.
